fetch_ifq: RTL and testbench
============================

Name: fetch_ifq

Overview:
- Parametrised successor to the single-request fetch front end.
- Tracks up to IFQ_DEPTH tagged, outstanding I$ line requests. Responses may return out of order; the block delivers lines to the instruction buffer strictly in program order.
- On redirect it kills in-flight requests by epoch-less slot state, so stale responses are absorbed without tag reuse hazards.
- Sits between next-PC logic (redirect source) and L1I (request/response), feeding ins_buffer.

Parameters:
- PC_WIDTH, 39, virtual PC width.
- FETCH_WIDTH, 128, I$ line payload bits. LINE_BYTES = FETCH_WIDTH/8, a power of two.
- IFQ_DEPTH, 4, outstanding request slots. Power of two, ≥2.
- ECAUSE_WIDTH, 4, exception cause width.
- RESET_VECTOR, 'h80000000, first fetch PC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- redirect_vld_i  in  1  flush and redirect (trap/ret/mispredict, pre-muxed).
- redirect_pc_i  in  PC_WIDTH  redirect target.
- stall_i  in  1  WFI/hold; blocks new issue only.
- req_vld_o  out  1  I$ request valid.
- req_rdy_i  in  1  I$ accepts request.
- req_tag_o  out  log2(IFQ_DEPTH)  slot index used as tag.
- req_pc_o  out  PC_WIDTH  line-aligned request address.
- resp_vld_i  in  1  I$ response valid (always accepted).
- resp_tag_i  in  log2(IFQ_DEPTH)  response tag.
- resp_data_i  in  FETCH_WIDTH  line data.
- resp_excp_vld_i  in  1  translation/access fault for this line.
- resp_ecause_i  in  ECAUSE_WIDTH  fault cause.
- line_vld_o  out  1  in-order line available.
- line_rdy_i  in  1  instruction buffer accepts line.
- line_pc_o  out  PC_WIDTH  entry PC; unaligned for the first line after redirect/reset.
- line_data_o  out  FETCH_WIDTH  line payload.
- line_excp_vld_o  out  1  line carries exception.
- line_ecause_o  out  ECAUSE_WIDTH  cause.
- outstanding_o  out  log2(IFQ_DEPTH)+1  slots in PEND or KILLED.
- empty_o  out  1  all slots FREE.

Behaviour:
- Slot state per entry is 2 bits: FREE, PEND, DONE, KILLED. Each slot holds pc, data, excp and ecause.
- Pointers:
  - alloc_ptr (issue) and ret_ptr (retire) wrap modulo IFQ_DEPTH.
  - fetch_pc register.
  - halted flag.
- Reset (rst_n low, asynchronous):
  - All slots FREE; alloc_ptr = ret_ptr = 0.
  - fetch_pc = RESET_VECTOR; halted = 0.
  - Outputs: req_vld_o = 0, line_vld_o = 0, outstanding_o = 0, empty_o = 1. Data outputs 0.
- Issue:
  - req_vld_o = slot[alloc_ptr]==FREE & !halted & !stall_i & !redirect_vld_i.
  - req_tag_o = alloc_ptr. req_pc_o = fetch_pc with the low log2(LINE_BYTES) bits zeroed.
  - On req_vld_o & req_rdy_i: slot gets PEND and pc = fetch_pc; alloc_ptr+1; fetch_pc = aligned(fetch_pc) + LINE_BYTES.
  - stall_i or redirect_vld_i may withdraw an unaccepted request. Otherwise req_vld_o and req fields hold until accepted.
- Response:
  - Tag in PEND: the slot becomes DONE and captures data, excp and ecause.
  - Tag in KILLED: the slot becomes FREE and data is dropped.
  - Tag in FREE or DONE: ignored; this is a protocol error and triggers a simulation-only assertion.
  - A captured excp sets halted, which stops further issue until redirect.
- Retire:
  - line_vld_o = slot[ret_ptr]==DONE & !redirect_vld_i.
  - Line outputs come combinationally from slot[ret_ptr].
  - On handshake: the slot becomes FREE and ret_ptr+1.
  - Zero-cycle bypass from response to line output is not provided. Minimum latency is response cycle +1.
- Redirect (highest priority):
  - Every PEND slot becomes KILLED; every DONE slot becomes FREE.
  - ret_ptr = alloc_ptr; fetch_pc = redirect_pc_i (unaligned kept); halted = 0.
  - Issue resumes the next cycle, only when slot[alloc_ptr] is FREE. A KILLED slot at alloc_ptr blocks issue until its response frees it.
- Simultaneous events:
  - Redirect plus a response to a PEND slot in the same cycle: the slot becomes FREE.
  - Redirect plus a response to a KILLED slot: FREE.
  - Redirect plus line_rdy_i: no retire occurs, because line_vld_o is masked.
  - Response plus retire on different slots: both take effect.
- Full: all slots non-FREE gives req_vld_o = 0.
- fetch_pc arithmetic wraps at 2^PC_WIDTH.
- outstanding_o = count of PEND + KILLED, registered and updated incrementally (±1 per event, net).

Decomposition:
- fetch_pkg holds:
  - The slot state enum: FREE=0, PEND=1, DONE=2, KILLED=3.
  - LINE_BYTES and offset-width localparams.
  - The ecause typedef.
- One sub-module, fetch_ifq_slot: per-slot state FSM plus payload register, instantiated IFQ_DEPTH times.
- Pointer and counter logic lives in the top.

Test Plan:
- Reset with req_rdy_i=1 and I$ responding in order after 2 cycles. Expect: requests at 0x80000000, 0x80000010, 0x80000020, 0x80000030 with tags 0..3, then stall (full). Lines retire in order, and issue resumes as slots free.
- Out-of-order responses, tags 2, 0, 3, 1. Expect line_vld_o first in the cycle after tag 0 arrives. Lines are then delivered in order 0x80000000…0x80000030 with the matching data.
- Redirect to 0x80001006 with tags 1 and 2 PEND. Expect:
  - Those slots become KILLED; outstanding_o stays 2.
  - Late responses for tags 1 and 2 produce no line.
  - The next request uses alloc_ptr, address 0x80001000. The first line_pc_o is 0x80001006, the next 0x80001010.
- Response with resp_excp_vld_i=1, ecause=12, for the second line. Expect:
  - The line retires with line_excp_vld_o=1 and ecause 12.
  - No further req_vld_o until a redirect.
- stall_i asserted while req_vld_o=1 and req_rdy_i=0. Expect req_vld_o to drop the same cycle and re-present the same pc/tag after stall_i falls. rst_n pulled low mid-stream clears everything immediately: empty_o=1, outstanding_o=0.

Source files
------------

// File: rtl/fetch_ifq_pkg.sv
// Shared types for the fetch request queue: slot state encoding and line geometry.
package fetch_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        DONE   = 2'd2,
        KILLED = 2'd3
    } slot_state_e;

    localparam int FETCH_WIDTH_DEF = 128;
    localparam int LINE_BYTES      = FETCH_WIDTH_DEF / 8;
    localparam int OFF_W           = $clog2(LINE_BYTES);
    localparam int ECAUSE_W        = 4;

    typedef logic [ECAUSE_W-1:0] ecause_t;

    function automatic int off_width(input int fetch_width);
        return $clog2(fetch_width / 8);
    endfunction
endpackage

// File: rtl/fetch_ifq_slot.sv
// One outstanding-request slot: lifecycle FSM plus the captured line payload.
module fetch_ifq_slot
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH     = 39,
    parameter int FETCH_WIDTH  = 128,
    parameter int ECAUSE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc,
    input  logic [PC_WIDTH-1:0]     alloc_pc,
    input  logic                    resp,
    input  logic [FETCH_WIDTH-1:0]  resp_data,
    input  logic                    resp_excp_vld,
    input  logic [ECAUSE_WIDTH-1:0] resp_ecause,
    input  logic                    retire,
    input  logic                    redirect,
    output slot_state_e             state,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [FETCH_WIDTH-1:0]  data,
    output logic                    excp_vld,
    output logic [ECAUSE_WIDTH-1:0] ecause
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FREE;
            pc       <= '0;
            data     <= '0;
            excp_vld <= 1'b0;
            ecause   <= '0;
        end else begin
            if (alloc) pc <= alloc_pc;
            if (resp && state == PEND && !redirect) begin
                data     <= resp_data;
                excp_vld <= resp_excp_vld;
                ecause   <= resp_ecause;
            end
            // A response landing with a redirect retires the kill immediately.
            case (state)
                FREE:   if (alloc) state <= PEND;
                PEND:   if (resp) state <= redirect ? FREE : DONE;
                        else if (redirect) state <= KILLED;
                DONE:   if (redirect || retire) state <= FREE;
                KILLED: if (resp) state <= FREE;
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: rtl/fetch_ifq.sv
// Multi-outstanding I$ fetch queue: tagged issue, out-of-order fill, in-order delivery.
module fetch_ifq
    import fetch_pkg::*;
#(
    parameter int          PC_WIDTH     = 39,
    parameter int          FETCH_WIDTH  = 128,
    parameter int          IFQ_DEPTH    = 4,
    parameter int          ECAUSE_WIDTH = 4,
    parameter logic [63:0] RESET_VECTOR = 64'h8000_0000,
    localparam int         TAG_W        = $clog2(IFQ_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_vld_i,
    input  logic [PC_WIDTH-1:0]     redirect_pc_i,
    input  logic                    stall_i,
    output logic                    req_vld_o,
    input  logic                    req_rdy_i,
    output logic [TAG_W-1:0]        req_tag_o,
    output logic [PC_WIDTH-1:0]     req_pc_o,
    input  logic                    resp_vld_i,
    input  logic [TAG_W-1:0]        resp_tag_i,
    input  logic [FETCH_WIDTH-1:0]  resp_data_i,
    input  logic                    resp_excp_vld_i,
    input  logic [ECAUSE_WIDTH-1:0] resp_ecause_i,
    output logic                    line_vld_o,
    input  logic                    line_rdy_i,
    output logic [PC_WIDTH-1:0]     line_pc_o,
    output logic [FETCH_WIDTH-1:0]  line_data_o,
    output logic                    line_excp_vld_o,
    output logic [ECAUSE_WIDTH-1:0] line_ecause_o,
    output logic [TAG_W:0]          outstanding_o,
    output logic                    empty_o
);
    localparam int LB = FETCH_WIDTH / 8;
    localparam int OW = off_width(FETCH_WIDTH);

    slot_state_e             st     [IFQ_DEPTH];
    logic [PC_WIDTH-1:0]     s_pc   [IFQ_DEPTH];
    logic [FETCH_WIDTH-1:0]  s_data [IFQ_DEPTH];
    logic                    s_excp [IFQ_DEPTH];
    logic [ECAUSE_WIDTH-1:0] s_ec   [IFQ_DEPTH];

    logic [TAG_W-1:0]    alloc_ptr, ret_ptr;
    logic [PC_WIDTH-1:0] fetch_pc, pc_aligned;
    logic                halted, issue, retire, resp_live, resp_pend;

    assign pc_aligned = {fetch_pc[PC_WIDTH-1:OW], OW'(0)};
    assign req_vld_o  = rst_n && st[alloc_ptr] == FREE && !halted && !stall_i && !redirect_vld_i;
    assign req_tag_o  = alloc_ptr;
    assign req_pc_o   = req_vld_o ? pc_aligned : '0;
    assign issue      = req_vld_o && req_rdy_i;

    assign resp_pend  = resp_vld_i && st[resp_tag_i] == PEND;
    assign resp_live  = resp_vld_i && (st[resp_tag_i] == PEND || st[resp_tag_i] == KILLED);

    assign line_vld_o      = rst_n && st[ret_ptr] == DONE && !redirect_vld_i;
    assign line_pc_o       = s_pc[ret_ptr];
    assign line_data_o     = s_data[ret_ptr];
    assign line_excp_vld_o = s_excp[ret_ptr];
    assign line_ecause_o   = s_ec[ret_ptr];
    assign retire          = line_vld_o && line_rdy_i;

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < IFQ_DEPTH; i++)
            if (st[i] != FREE) empty_o = 1'b0;
    end

    for (genvar g = 0; g < IFQ_DEPTH; g++) begin : g_slot
        fetch_ifq_slot #(
            .PC_WIDTH     (PC_WIDTH),
            .FETCH_WIDTH  (FETCH_WIDTH),
            .ECAUSE_WIDTH (ECAUSE_WIDTH)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .alloc         (issue && alloc_ptr == TAG_W'(g)),
            .alloc_pc      (fetch_pc),
            .resp          (resp_vld_i && resp_tag_i == TAG_W'(g)),
            .resp_data     (resp_data_i),
            .resp_excp_vld (resp_excp_vld_i),
            .resp_ecause   (resp_ecause_i),
            .retire        (retire && ret_ptr == TAG_W'(g)),
            .redirect      (redirect_vld_i),
            .state         (st[g]),
            .pc            (s_pc[g]),
            .data          (s_data[g]),
            .excp_vld      (s_excp[g]),
            .ecause        (s_ec[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr     <= '0;
            ret_ptr       <= '0;
            fetch_pc      <= RESET_VECTOR[PC_WIDTH-1:0];
            halted        <= 1'b0;
            outstanding_o <= '0;
        end else begin
            // Redirect and issue are exclusive, so the counter sees at most +1/-1.
            if (issue && !resp_live)      outstanding_o <= outstanding_o + 1'b1;
            else if (!issue && resp_live) outstanding_o <= outstanding_o - 1'b1;
            if (issue) alloc_ptr <= alloc_ptr + 1'b1;
            if (redirect_vld_i) begin
                ret_ptr  <= alloc_ptr;
                fetch_pc <= redirect_pc_i;
                halted   <= 1'b0;
            end else begin
                if (issue)  fetch_pc <= pc_aligned + PC_WIDTH'(LB);
                if (retire) ret_ptr <= ret_ptr + 1'b1;
                if (resp_pend && resp_excp_vld_i) halted <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    resp_tag_ok: assert property (@(posedge clk) disable iff (!rst_n)
        resp_vld_i |-> (st[resp_tag_i] == PEND || st[resp_tag_i] == KILLED));
`endif
endmodule

// File: tb/tb_fetch_ifq.sv
// Directed per-cycle vector bench for fetch_ifq plus reset and redirect corner sequences.
module tb_fetch_ifq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         redirect_vld_i = 1'b0;
    logic [38:0]  redirect_pc_i = '0;
    logic         stall_i = 1'b0;
    logic         req_vld_o;
    logic         req_rdy_i = 1'b0;
    logic [1:0]   req_tag_o;
    logic [38:0]  req_pc_o;
    logic         resp_vld_i = 1'b0;
    logic [1:0]   resp_tag_i = '0;
    logic [127:0] resp_data_i = '0;
    logic         resp_excp_vld_i = 1'b0;
    logic [3:0]   resp_ecause_i = '0;
    logic         line_vld_o;
    logic         line_rdy_i = 1'b0;
    logic [38:0]  line_pc_o;
    logic [127:0] line_data_o;
    logic         line_excp_vld_o;
    logic [3:0]   line_ecause_o;
    logic [2:0]   outstanding_o;
    logic         empty_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_ifq dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_vld_i(redirect_vld_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
        .req_vld_o(req_vld_o), .req_rdy_i(req_rdy_i), .req_tag_o(req_tag_o), .req_pc_o(req_pc_o),
        .resp_vld_i(resp_vld_i), .resp_tag_i(resp_tag_i), .resp_data_i(resp_data_i),
        .resp_excp_vld_i(resp_excp_vld_i), .resp_ecause_i(resp_ecause_i),
        .line_vld_o(line_vld_o), .line_rdy_i(line_rdy_i), .line_pc_o(line_pc_o),
        .line_data_o(line_data_o), .line_excp_vld_o(line_excp_vld_o), .line_ecause_o(line_ecause_o),
        .outstanding_o(outstanding_o), .empty_o(empty_o)
    );

    typedef struct {
        bit rdr; logic [38:0] rpc; bit stall; bit rrdy; bit rsv; int rtag; int rdat; bit rex; int rec; bit lrdy;
        bit e_req; int e_tag; logic [38:0] e_rpc; bit e_lv; logic [38:0] e_lpc; int e_ldat; bit e_lex; int e_lec;
        int e_out; bit e_empty;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [127:0] line_of(input int d);
        return {4{32'(d)}};
    endfunction

    function automatic void add(input bit rdr, input logic [38:0] rpc, input bit stall, input bit rrdy,
                                input bit rsv, input int rtag, input int rdat, input bit rex, input int rec,
                                input bit lrdy, input bit e_req, input int e_tag, input logic [38:0] e_rpc,
                                input bit e_lv, input logic [38:0] e_lpc, input int e_ldat, input bit e_lex,
                                input int e_lec, input int e_out, input bit e_empty);
        vec_t v;
        v.rdr = rdr; v.rpc = rpc; v.stall = stall; v.rrdy = rrdy; v.rsv = rsv; v.rtag = rtag; v.rdat = rdat;
        v.rex = rex; v.rec = rec; v.lrdy = lrdy; v.e_req = e_req; v.e_tag = e_tag; v.e_rpc = e_rpc;
        v.e_lv = e_lv; v.e_lpc = e_lpc; v.e_ldat = e_ldat; v.e_lex = e_lex; v.e_lec = e_lec;
        v.e_out = e_out; v.e_empty = e_empty;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        redirect_vld_i = 0; redirect_pc_i = '0; stall_i = 0; req_rdy_i = 0; resp_vld_i = 0;
        resp_tag_i = '0; resp_data_i = '0; resp_excp_vld_i = 0; resp_ecause_i = '0; line_rdy_i = 0;
    endtask

    initial begin
        // Per cycle: rdr rpc stall rrdy rsv rtag rdat rex rec lrdy | req tag rpc lv lpc ldat lex lec out empty
        add(0,0,0,1, 0,0,0,0,0, 0,  1,0,39'h80000000, 0,0,0,0,0, 0,1);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,1,39'h80000010, 0,0,0,0,0, 1,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,2,39'h80000020, 0,0,0,0,0, 2,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,3,39'h80000030, 0,0,0,0,0, 3,0);
        add(0,0,0,1, 1,2,'hA2,0,0, 0,  0,0,0, 0,0,0,0,0, 4,0);
        add(0,0,0,1, 1,0,'hA0,0,0, 0,  0,0,0, 0,0,0,0,0, 3,0);
        add(0,0,0,1, 1,3,'hA3,0,0, 0,  0,0,0, 1,39'h80000000,'hA0,0,0, 2,0);
        add(0,0,0,1, 1,1,'hA1,0,0, 1,  0,0,0, 1,39'h80000000,'hA0,0,0, 1,0);
        add(0,0,0,0, 0,0,0,0,0, 1,  1,0,39'h80000040, 1,39'h80000010,'hA1,0,0, 0,0);
        add(0,0,1,0, 0,0,0,0,0, 1,  0,0,0, 1,39'h80000020,'hA2,0,0, 0,0);
        add(0,0,0,1, 0,0,0,0,0, 1,  1,0,39'h80000040, 1,39'h80000030,'hA3,0,0, 0,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,1,39'h80000050, 0,0,0,0,0, 1,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,2,39'h80000060, 0,0,0,0,0, 2,0);
        add(0,0,0,0, 1,0,'hB4,0,0, 0,  1,3,39'h80000070, 0,0,0,0,0, 3,0);
        add(0,0,0,0, 0,0,0,0,0, 1,  1,3,39'h80000070, 1,39'h80000040,'hB4,0,0, 2,0);
        add(1,39'h80001006,0,1, 0,0,0,0,0, 1,  0,0,0, 0,0,0,0,0, 2,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,3,39'h80001000, 0,0,0,0,0, 2,0);
        add(0,0,0,1, 1,1,'hEE,0,0, 0,  1,0,39'h80001010, 0,0,0,0,0, 3,0);
        add(0,0,0,0, 1,3,'hC5,0,0, 0,  1,1,39'h80001020, 0,0,0,0,0, 3,0);
        add(0,0,0,0, 1,2,'hEE,0,0, 1,  1,1,39'h80001020, 1,39'h80001006,'hC5,0,0, 2,0);
        add(0,0,0,0, 1,0,'hC6,0,0, 0,  1,1,39'h80001020, 0,0,0,0,0, 1,0);
        add(0,0,0,1, 0,0,0,0,0, 1,  1,1,39'h80001020, 1,39'h80001010,'hC6,0,0, 0,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  1,2,39'h80001030, 0,0,0,0,0, 1,0);
        add(0,0,0,0, 1,1,'hD7,0,0, 0,  1,3,39'h80001040, 0,0,0,0,0, 2,0);
        add(0,0,0,0, 1,2,'hD8,1,12, 1, 1,3,39'h80001040, 1,39'h80001020,'hD7,0,0, 1,0);
        add(0,0,0,1, 0,0,0,0,0, 1,  0,0,0, 1,39'h80001030,'hD8,1,12, 0,0);
        add(0,0,0,1, 0,0,0,0,0, 0,  0,0,0, 0,0,0,0,0, 0,1);
        add(1,39'h80002000,0,1, 0,0,0,0,0, 0,  0,0,0, 0,0,0,0,0, 0,1);
        add(0,0,0,0, 0,0,0,0,0, 0,  1,3,39'h80002000, 0,0,0,0,0, 0,1);

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_vld", req_vld_o, 0);
        chk("rst_line_vld", line_vld_o, 0);
        chk("rst_out", outstanding_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_line_data", line_data_o, 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            redirect_vld_i = tbl[i].rdr; redirect_pc_i = tbl[i].rpc; stall_i = tbl[i].stall;
            req_rdy_i = tbl[i].rrdy; resp_vld_i = tbl[i].rsv; resp_tag_i = 2'(tbl[i].rtag);
            resp_data_i = line_of(tbl[i].rdat); resp_excp_vld_i = tbl[i].rex;
            resp_ecause_i = 4'(tbl[i].rec); line_rdy_i = tbl[i].lrdy;
            #3;
            chk($sformatf("r%0d_req_vld", i), req_vld_o, tbl[i].e_req);
            if (tbl[i].e_req) begin
                chk($sformatf("r%0d_req_tag", i), req_tag_o, tbl[i].e_tag);
                chk($sformatf("r%0d_req_pc", i), req_pc_o, tbl[i].e_rpc);
            end
            chk($sformatf("r%0d_line_vld", i), line_vld_o, tbl[i].e_lv);
            if (tbl[i].e_lv) begin
                chk($sformatf("r%0d_line_pc", i), line_pc_o, tbl[i].e_lpc);
                chk($sformatf("r%0d_line_data", i), line_data_o, line_of(tbl[i].e_ldat));
                chk($sformatf("r%0d_line_excp", i), line_excp_vld_o, tbl[i].e_lex);
                if (tbl[i].e_lex) chk($sformatf("r%0d_line_ecause", i), line_ecause_o, tbl[i].e_lec);
            end
            chk($sformatf("r%0d_outstanding", i), outstanding_o, tbl[i].e_out);
            chk($sformatf("r%0d_empty", i), empty_o, tbl[i].e_empty);
        end

        // Reset asserted mid-stream with one request outstanding.
        @(posedge clk); #1; idle(); req_rdy_i = 1; #3;
        chk("mid_req_vld", req_vld_o, 1);
        @(posedge clk); #1; idle(); #3;
        chk("mid_out_pre", outstanding_o, 1);
        chk("mid_empty_pre", empty_o, 0);
        rst_n = 0; #1;
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_out", outstanding_o, 0);
        chk("mid_rst_req_vld", req_vld_o, 0);
        chk("mid_rst_line_vld", line_vld_o, 0);
        @(posedge clk); #1; rst_n = 1;

        // Redirect coinciding with the response for a pending slot frees it outright.
        @(posedge clk); #1; idle(); req_rdy_i = 1; #3;
        chk("rr_req_vld", req_vld_o, 1);
        chk("rr_req_pc", req_pc_o, 39'h80000000);
        chk("rr_req_tag", req_tag_o, 0);
        @(posedge clk); #1; idle();
        redirect_vld_i = 1; redirect_pc_i = 39'h80000100; resp_vld_i = 1; resp_tag_i = 0;
        resp_data_i = line_of('h55); #3;
        chk("rr_out_during", outstanding_o, 1);
        chk("rr_req_masked", req_vld_o, 0);
        @(posedge clk); #1; idle(); #3;
        chk("rr_out_after", outstanding_o, 0);
        chk("rr_empty_after", empty_o, 1);
        chk("rr_line_vld", line_vld_o, 0);
        chk("rr_req_vld2", req_vld_o, 1);
        chk("rr_req_tag2", req_tag_o, 1);
        chk("rr_req_pc2", req_pc_o, 39'h80000100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
